// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_pkg                                                |
// | Description : Opcodes, flag indices and arbiter FSM states shared    |
// |               by alu32bit and alu_arbiter.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_SHR  = 4'b0110;
  localparam logic [3:0] OP_SHL  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_REM  = 4'b1010;

  // Highest supported code; anything above it is reported as an error.
  localparam logic [3:0] OP_LAST = 4'b1010;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu32bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu32bit                                               |
// | Description : Purely combinational 32-bit ALU with N/Z/C/V flags.    |
// |               Carry/overflow are only meaningful for ADD, SUB, CMP;  |
// |               CMP returns zero and reports the A-B flags.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu32bit
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_control,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic        err
);

  logic [32:0] sum_add;
  logic [32:0] sum_sub;
  logic [31:0] prod;
  logic        add_ovf;
  logic        sub_ovf;

  assign sum_add = {1'b0, a} + {1'b0, b};
  // Subtraction as A + ~B + 1, so carry-out = 1 means "no borrow".
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + 33'd1;
  assign prod    = a * b;
  assign add_ovf = (a[31] == b[31]) && (sum_add[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (sum_sub[31] != a[31]);

  logic [31:0] flag_src;
  logic        carry;
  logic        ovf;

  // Operation select; flag_src is the value N and Z are derived from.
  always_comb begin
    result   = 32'd0;
    flag_src = 32'd0;
    carry    = 1'b0;
    ovf      = 1'b0;
    err      = 1'b0;
    case (alu_control)
      OP_ADD: begin
        result = sum_add[31:0];
        carry  = sum_add[32];
        ovf    = add_ovf;
      end
      OP_SUB: begin
        result = sum_sub[31:0];
        carry  = sum_sub[32];
        ovf    = sub_ovf;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_MUL: result = prod;
      OP_DIV: result = (b == 32'd0) ? 32'd0 : a / b;
      OP_SHR: result = a >> b[4:0];
      OP_SHL: result = a << b[4:0];
      OP_CMP: begin
        result = 32'd0;
        carry  = sum_sub[32];
        ovf    = sub_ovf;
      end
      OP_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_REM: result = (b == 32'd0) ? 32'd0 : a % b;
      default: begin
        result = 32'd0;
        err    = 1'b1;
      end
    endcase
    flag_src = (alu_control == OP_CMP) ? sum_sub[31:0] : result;
  end

  // Pack the flags into {N, Z, C, V}.
  always_comb begin
    flags        = 4'd0;
    flags[FLG_N] = flag_src[31];
    flags[FLG_Z] = (flag_src == 32'd0);
    flags[FLG_C] = carry;
    flags[FLG_V] = ovf;
  end

endmodule : alu32bit
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_arbiter                                            |
// | Description : Round-robin arbiter/sequencer sharing one alu32bit     |
// |               between two valid/ready clients. One operation in      |
// |               flight: IDLE (accept) -> EXEC (compute) -> RESP.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_arbiter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ReqValid,
  output logic [1:0]  ReqReady,
  input  logic [63:0] ReqA,
  input  logic [63:0] ReqB,
  input  logic [7:0]  ReqOp,
  output logic [1:0]  RspValid,
  input  logic [1:0]  RspReady,
  output logic [31:0] RspResult,
  output logic [3:0]  RspFlags,
  output logic        RspErr,
  output logic        Busy
);

  state_t      state;
  state_t      state_next;

  logic        last_served;
  logic        grant;
  logic        req_fire;
  logic        rsp_fire;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  op_code;
  logic        op_idx;

  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;

  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        alu_err;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    case (ReqValid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_served;
      default: grant = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the handshake outputs on both channels.
  always_comb begin
    state_next = state;
    ReqReady   = 2'b00;
    RspValid   = 2'b00;
    req_fire   = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      ST_IDLE: begin
        ReqReady[grant] = ReqValid[grant];
        req_fire        = ReqValid[grant];
        if (req_fire) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        RspValid[op_idx] = 1'b1;
        rsp_fire         = RspReady[op_idx];
        if (rsp_fire) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operand capture on accept, result capture at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_served <= 1'b1;
      op_idx      <= 1'b0;
      op_a        <= 32'd0;
      op_b        <= 32'd0;
      op_code     <= 4'd0;
      rsp_result  <= 32'd0;
      rsp_flags   <= 4'd0;
      rsp_err     <= 1'b0;
    end else begin
      if (req_fire) begin
        last_served <= grant;
        op_idx      <= grant;
        op_a        <= grant ? ReqA[63:32] : ReqA[31:0];
        op_b        <= grant ? ReqB[63:32] : ReqB[31:0];
        op_code     <= grant ? ReqOp[7:4]  : ReqOp[3:0];
      end
      if (state == ST_EXEC) begin
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
        rsp_err    <= alu_err;
      end
    end
  end

  // The ALU only ever sees registered operands, so EXEC gets a full period.
  alu32bit u_alu (
    .a           (op_a),
    .b           (op_b),
    .alu_control (op_code),
    .result      (alu_result),
    .flags       (alu_flags),
    .err         (alu_err)
  );

  assign RspResult = rsp_result;
  assign RspFlags  = rsp_flags;
  assign RspErr    = rsp_err;
  assign Busy      = (state != ST_IDLE);

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alu_arbiter                                         |
// | Description : Directed self-checking bench for alu_arbiter.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  ReqValid;
  logic [1:0]  ReqReady;
  logic [63:0] ReqA;
  logic [63:0] ReqB;
  logic [7:0]  ReqOp;
  logic [1:0]  RspValid;
  logic [1:0]  RspReady;
  logic [31:0] RspResult;
  logic [3:0]  RspFlags;
  logic        RspErr;
  logic        Busy;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  alu_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqA      (ReqA),
    .ReqB      (ReqB),
    .ReqOp     (ReqOp),
    .RspValid  (RspValid),
    .RspReady  (RspReady),
    .RspResult (RspResult),
    .RspFlags  (RspFlags),
    .RspErr    (RspErr),
    .Busy      (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    ReqA[i*32 +: 32] = a;
    ReqB[i*32 +: 32] = b;
    ReqOp[i*4 +: 4]  = op;
  endtask

  // Hard stop in case anything above stalls.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int n;
  int last_t;

  initial begin
    rst = 1'b1; ReqValid = 2'b00; RspReady = 2'b00;
    ReqA = '0; ReqB = '0; ReqOp = '0;
    step(); step();
    rst = 1'b0; #1;
    chk("rst_reqready", ReqReady, 0);
    chk("rst_rspvalid", RspValid, 0);
    chk("rst_result", RspResult, 0);
    chk("rst_flags", RspFlags, 0);
    chk("rst_err", RspErr, 0);
    chk("rst_busy", Busy, 0);

    // Requester 0 add: 5 + 7
    set_req(0, 32'd5, 32'd7, OP_ADD);
    ReqValid = 2'b01; RspReady = 2'b11; #1;
    chk("add_accept", ReqReady, 2'b01);
    step(); ReqValid = 2'b00; #1;
    chk("add_exec_busy", Busy, 1);
    chk("add_exec_novalid", RspValid, 0);
    step();
    chk("add_rspvalid", RspValid, 2'b01);
    chk("add_result", RspResult, 32'd12);
    chk("add_flags", RspFlags, 4'b0000);
    chk("add_err", RspErr, 0);
    step();
    chk("add_idle", Busy, 0);
    chk("add_rsp_done", RspValid, 0);

    // Tie after reset: requester 0 first, then requester 1
    rst = 1'b1; step(); rst = 1'b0;
    set_req(0, 32'd3, 32'd5, OP_SUB);
    set_req(1, 32'hFF, 32'h0F, OP_AND);
    ReqValid = 2'b11; #1;
    chk("tie_grant0", ReqReady, 2'b01);
    step(); ReqValid = 2'b10; #1;
    chk("tie_exec_noaccept", ReqReady, 2'b00);
    step();
    chk("sub_rspvalid", RspValid, 2'b01);
    chk("sub_result", RspResult, 32'hFFFFFFFE);
    chk("sub_flags", RspFlags, 4'b1000);
    step();
    chk("tie_grant1", ReqReady, 2'b10);
    step(); ReqValid = 2'b00;
    step();
    chk("and_rspvalid", RspValid, 2'b10);
    chk("and_result", RspResult, 32'h0000000F);
    chk("and_flags", RspFlags, 4'b0000);
    step();
    chk("and_idle", Busy, 0);

    // Backpressure: hold RESP for 5 cycles while both requesters wait
    set_req(0, 32'd6, 32'd7, OP_MUL);
    ReqValid = 2'b01; RspReady = 2'b00; #1;
    chk("bp_accept", ReqReady, 2'b01);
    step(); ReqValid = 2'b11;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k), RspValid, 2'b01);
      chk($sformatf("bp_result%0d", k), RspResult, 32'd42);
      chk($sformatf("bp_flags%0d", k), RspFlags, 4'b0000);
      chk($sformatf("bp_reqready%0d", k), ReqReady, 2'b00);
      chk($sformatf("bp_busy%0d", k), Busy, 1);
      step();
    end
    RspReady = 2'b11;
    step();
    chk("bp_release_idle", Busy, 0);
    chk("bp_release_grant1", ReqReady, 2'b10);
    ReqValid = 2'b00; #1;

    // Divide by zero on requester 1
    set_req(1, 32'd9, 32'd0, OP_DIV);
    ReqValid = 2'b10; #1;
    chk("div_accept", ReqReady, 2'b10);
    step(); ReqValid = 2'b00;
    step();
    chk("div_rspvalid", RspValid, 2'b10);
    chk("div_result", RspResult, 32'd0);
    chk("div_flags", RspFlags, 4'b0100);
    chk("div_err", RspErr, 0);
    step();

    // Unsupported opcode on requester 0
    set_req(0, 32'h1234, 32'h55, 4'b1100);
    ReqValid = 2'b01; #1;
    chk("bad_accept", ReqReady, 2'b01);
    step(); ReqValid = 2'b00;
    step();
    chk("bad_rspvalid", RspValid, 2'b01);
    chk("bad_result", RspResult, 32'd0);
    chk("bad_flags", RspFlags, 4'b0100);
    chk("bad_err", RspErr, 1);
    step();

    // Reset during EXEC discards the operation (pointer was 0 before reset)
    set_req(0, 32'h7FFFFFFF, 32'd1, OP_ADD);
    ReqValid = 2'b01; #1;
    chk("rexec_accept", ReqReady, 2'b01);
    step(); ReqValid = 2'b00; rst = 1'b1;
    step(); rst = 1'b0; #1;
    chk("rexec_busy", Busy, 0);
    chk("rexec_rspvalid", RspValid, 0);
    chk("rexec_result", RspResult, 0);
    chk("rexec_flags", RspFlags, 0);
    chk("rexec_err", RspErr, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rexec_norsp%0d", k), RspValid, 0);
    end

    // Continuous contention: grant order 0,1,0,1 with one accept every 3 cycles
    set_req(0, 32'd1, 32'd2, OP_ADD);
    set_req(1, 32'd10, 32'd4, OP_SUB);
    ReqValid = 2'b11; RspReady = 2'b11; #1;
    n = 0; last_t = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (ReqReady != 2'b00) begin
        chk($sformatf("rr_order%0d", n), ReqReady, (n % 2 == 0) ? 2'b01 : 2'b10);
        if (n > 0) chk($sformatf("rr_gap%0d", n), c - last_t, 3);
        last_t = c;
        n++;
      end
      if (RspValid == 2'b01) chk("rr_result0", RspResult, 32'd3);
      if (RspValid == 2'b10) chk("rr_result1", RspResult, 32'd6);
      step();
    end
    chk("rr_accepts", n, 4);
    ReqValid = 2'b00;
    step(); step(); step();
    chk("final_idle", Busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_alu_arbiter
`default_nettype wire
